// File: rtl/hero_collision.sv
// Wall/hero collision scanner: snapshots both heroes, walks the wall ROM once per scan
// and commits a double-buffered 8-bit blocked vector. Optional feature: HERO_MUTUAL_BLOCK_EN.
module hero_collision #(
   parameter int NUM_WALLS   = 32,
   parameter int ADDR_W      = 5,
   parameter int SQUARE_SIDE = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [23:0]       x_pos,
   input  logic [23:0]       y_pos,
   output logic [ADDR_W-1:0] wall_addr,
   input  logic [47:0]       wall_data,
   output logic [7:0]        collision,
   output logic              scan_done
);

   typedef enum logic [1:0] {
      ST_LATCH  = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [12:0]       SIDE     = 13'(SQUARE_SIDE);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WALLS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [23:0]       x_snap_q, x_snap_d;
   logic [23:0]       y_snap_q, y_snap_d;
   logic [7:0]        acc_q, acc_d;
   logic [7:0]        collision_q, collision_d;
   logic              scan_done_q, scan_done_d;

   logic [12:0] wx0, wy0, wx1, wy1;
   logic [7:0]  wall_hits;
   logic [7:0]  mutual_hits;

   // Square of side SIDE at (qx, qy) overlaps [x0,x1) x [y0,y1); empty rectangles never hit.
   function automatic logic rect_hit(input logic [12:0] qx, input logic [12:0] qy,
                                     input logic [12:0] x0, input logic [12:0] y0,
                                     input logic [12:0] x1, input logic [12:0] y1);
      return (x1 > x0) && (y1 > y0) &&
             (qx < x1) && ((qx + SIDE) > x0) &&
             (qy < y1) && ((qy + SIDE) > y0);
   endfunction

   // Returns {up, down, right, left}; stepping off the left or top edge is always blocked.
   function automatic logic [3:0] probe_hits(input logic [11:0] px, input logic [11:0] py,
                                             input logic [12:0] x0, input logic [12:0] y0,
                                             input logic [12:0] x1, input logic [12:0] y1);
      logic [12:0] ex;
      logic [12:0] ey;
      logic [3:0]  r;
      ex   = {1'b0, px};
      ey   = {1'b0, py};
      r[0] = (px == 12'd0) || rect_hit(ex - 13'd1, ey, x0, y0, x1, y1);
      r[1] = rect_hit(ex + 13'd1, ey, x0, y0, x1, y1);
      r[2] = rect_hit(ex, ey + 13'd1, x0, y0, x1, y1);
      r[3] = (py == 12'd0) || rect_hit(ex, ey - 13'd1, x0, y0, x1, y1);
      return r;
   endfunction

   always_comb begin
      wx0 = {1'b0, wall_data[47:36]};
      wy0 = {1'b0, wall_data[35:24]};
      wx1 = {1'b0, wall_data[23:12]};
      wy1 = {1'b0, wall_data[11:0]};
      wall_hits = {probe_hits(x_snap_q[23:12], y_snap_q[23:12], wx0, wy0, wx1, wy1),
                   probe_hits(x_snap_q[11:0],  y_snap_q[11:0],  wx0, wy0, wx1, wy1)};
   end

`ifdef HERO_MUTUAL_BLOCK_EN
   // Each hero's probes are tested against the other hero's snapshot square.
   always_comb begin
      mutual_hits = {probe_hits(x_snap_q[23:12], y_snap_q[23:12],
                                {1'b0, x_snap_q[11:0]}, {1'b0, y_snap_q[11:0]},
                                {1'b0, x_snap_q[11:0]} + SIDE, {1'b0, y_snap_q[11:0]} + SIDE),
                     probe_hits(x_snap_q[11:0], y_snap_q[11:0],
                                {1'b0, x_snap_q[23:12]}, {1'b0, y_snap_q[23:12]},
                                {1'b0, x_snap_q[23:12]} + SIDE, {1'b0, y_snap_q[23:12]} + SIDE)};
   end
`else
   always_comb begin
      mutual_hits = 8'h00;
   end
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      x_snap_d    = x_snap_q;
      y_snap_d    = y_snap_q;
      acc_d       = acc_q;
      collision_d = collision_q;
      scan_done_d = 1'b0;
      case (state_q)
         ST_LATCH: begin
            x_snap_d = x_pos;
            y_snap_d = y_pos;
            acc_d    = 8'h00;
            idx_d    = '0;
            state_d  = ST_SCAN;
         end
         ST_SCAN: begin
            // wall_data here is the wall addressed in the previous cycle, i.e. wall idx_q.
            acc_d = acc_q | wall_hits;
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            collision_d = acc_q | mutual_hits;
            scan_done_d = 1'b1;
            state_d     = ST_LATCH;
         end
         default: begin
            state_d = ST_LATCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_LATCH;
         idx_q       <= '0;
         x_snap_q    <= 24'h0;
         y_snap_q    <= 24'h0;
         acc_q       <= 8'h00;
         collision_q <= 8'hFF;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         x_snap_q    <= x_snap_d;
         y_snap_q    <= y_snap_d;
         acc_q       <= acc_d;
         collision_q <= collision_d;
         scan_done_q <= scan_done_d;
      end
   end

   assign wall_addr = (state_q == ST_SCAN) ? (idx_q + ADDR_W'(1)) : '0;
   assign collision = collision_q;
   assign scan_done = scan_done_q;

endmodule

// File: tb/tb_hero_collision.sv
// Randomized scoreboard bench for hero_collision with a small wall ROM (4 walls).
// Expected vectors come from a direct geometric model of the blocking rules.
module tb_hero_collision;

   localparam int NW   = 4;
   localparam int AW   = 3;
   localparam int S    = 60;
   localparam int NSCN = 40;
   localparam int RST_SCN = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [23:0]   x_pos = 24'h0;
   logic [23:0]   y_pos = 24'h0;
   logic [AW-1:0] wall_addr;
   logic [47:0]   wall_data = 48'h0;
   logic [7:0]    collision;
   logic          scan_done;

   logic [47:0] rom [NW];
   logic [7:0]  exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;

   hero_collision #(.NUM_WALLS(NW), .ADDR_W(AW), .SQUARE_SIDE(S)) dut (
      .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
      .wall_addr(wall_addr), .wall_data(wall_data),
      .collision(collision), .scan_done(scan_done)
   );

   // ---- clock / ROM ----
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (int'(wall_addr) < NW) wall_data <= rom[int'(wall_addr)];
      else                      wall_data <= 48'h0;
   end

   // ---- reference model ----
   function automatic logic [47:0] make_wall(input int x0, input int y0, input int x1, input int y1);
      return {12'(x0), 12'(y0), 12'(x1), 12'(y1)};
   endfunction

   function automatic bit overlaps(input int qx, input int qy, input int x0, input int y0,
                                   input int x1, input int y1);
      return (x1 > x0) && (y1 > y0) && (qx < x1) && (qx + S > x0) && (qy < y1) && (qy + S > y0);
   endfunction

   function automatic logic [7:0] model(input int ax, input int ay, input int bx, input int by);
      int px[2];
      int py[2];
      int dx[4];
      int dy[4];
      logic [7:0] r;
      px = '{ax, bx};
      py = '{ay, by};
      dx = '{-1, 1, 0, 0};
      dy = '{0, 0, 1, -1};
      r = 8'h00;
      for (int h = 0; h < 2; h++) begin
         for (int d = 0; d < 4; d++) begin
            int qx;
            int qy;
            bit blk;
            qx  = px[h] + dx[d];
            qy  = py[h] + dy[d];
            blk = (qx < 0) || (qy < 0);
            for (int w = 0; w < NW; w++) begin
               blk |= overlaps(qx, qy, int'(rom[w][47:36]), int'(rom[w][35:24]),
                               int'(rom[w][23:12]), int'(rom[w][11:0]));
            end
`ifdef HERO_MUTUAL_BLOCK_EN
            blk |= overlaps(qx, qy, px[1-h], py[1-h], px[1-h] + S, py[1-h] + S);
`endif
            r[h*4+d] = blk;
         end
      end
      return r;
   endfunction

   // ---- driver tasks ----
   task automatic place(input int ax, input int ay, input int bx, input int by);
      x_pos = {12'(bx), 12'(ax)};
      y_pos = {12'(by), 12'(ay)};
      exp_q.push_back(model(ax, ay, bx, by));
   endtask

   function automatic int rand_pos();
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) return 0;
      if (sel == 1) return 4095;
      return int'($urandom_range(0, 1000));
   endfunction

   task automatic setup_scenario(input int k);
      for (int w = 0; w < NW; w++) rom[w] = 48'h0;
      case (k)
         0: place(542, 648, 422, 648);
         1: begin rom[0] = make_wall(602, 0, 700, 800); place(542, 100, 2000, 2000); end
         2: begin rom[0] = make_wall(602, 0, 700, 800); place(541, 100, 2000, 2000); end
         3: place(300, 300, 1000, 0);
         4: place(0, 500, 4095, 4095);
         5: place(500, 300, 560, 300);
         6: begin rom[1] = make_wall(700, 0, 602, 800); place(542, 100, 1500, 1500); end
         7: begin rom[3] = make_wall(100, 200, 300, 400); place(150, 139, 301, 250); end
         default: begin
            for (int w = 0; w < NW; w++) begin
               int x0;
               int y0;
               x0 = int'($urandom_range(0, 900));
               y0 = int'($urandom_range(0, 900));
               if ($urandom_range(0, 5) == 0)
                  rom[w] = make_wall(x0, y0, x0 - int'($urandom_range(0, 50)), y0 + 100);
               else
                  rom[w] = make_wall(x0, y0, x0 + int'($urandom_range(1, 200)),
                                     y0 + int'($urandom_range(1, 200)));
            end
            place(rand_pos(), rand_pos(), rand_pos(), rand_pos());
         end
      endcase
   endtask

   // ---- scoreboard / monitor ----
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic       rst_at_edge = 1'b0;
   int         phase = 0;
   logic [7:0] prev_col = 8'hFF;

   always @(posedge clk) rst_at_edge <= rst;

   always @(negedge clk) begin
      if (rst_at_edge) begin
         check("reset_collision", 32'(collision), 32'hFF);
         check("reset_scan_done", 32'(scan_done), 32'h0);
         phase    = 0;
         prev_col = 8'hFF;
      end else if (scan_done) begin
         check("period", 32'(phase), 32'(NW + 1));
         if (exp_q.size() == 0) begin
            check("unexpected_commit", 32'(scan_done), 32'h0);
         end else begin
            check("commit", 32'(collision), 32'(exp_q.pop_front()));
         end
         phase    = 0;
         prev_col = collision;
      end else begin
         phase++;
         check("hold", 32'(collision), 32'(prev_col));
         if (phase > NW + 1) check("scan_done_missing", 32'(scan_done), 32'h1);
      end
      if (phase < NW) check("wall_addr", 32'(wall_addr), 32'(phase));
   end

   // ---- stimulus ----
   initial begin
      bit timed_out;
      timed_out = 1'b0;
      setup_scenario(0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= NSCN && !timed_out; k++) begin
         int budget;
         budget = 0;
         do begin
            @(negedge clk);
            budget++;
         end while (!scan_done && budget < 100);
         if (!scan_done) begin
            check("scan_done_timeout", 32'(scan_done), 32'h1);
            timed_out = 1'b1;
         end else if (k < NSCN) begin
            setup_scenario(k);
            if (k == RST_SCN) begin
               repeat (3) @(negedge clk);
               rst = 1'b1;
               @(negedge clk);
               exp_q.delete();
               exp_q.push_back(model(int'(x_pos[11:0]), int'(y_pos[11:0]),
                                     int'(x_pos[23:12]), int'(y_pos[23:12])));
               rst = 1'b0;
            end else if (k >= 2) begin
               // Positions moving mid-scan must not affect the scan already in progress.
               repeat (int'($urandom_range(1, NW))) @(negedge clk);
               x_pos = {12'(rand_pos()), 12'(rand_pos())};
               y_pos = {12'(rand_pos()), 12'(rand_pos())};
            end
         end
      end
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hero_collision.md
# hero_collision

Computes the 8-bit `collision` vector consumed by the hero movement controller. It sits directly upstream of that controller. Each scan it snapshots both heroes' packed positions and walks the maze wall table through an external synchronous ROM. It then reports, per hero and per direction, whether a one-pixel step would overlap a wall. Results are double-buffered, so `collision` stays stable for a whole scan period and changes only at commit.

## Interface
Parameters:
- `NUM_WALLS`, default 32: number of wall rectangles in the ROM (range 1..2^ADDR_W).
- `ADDR_W`, default 5: wall ROM address width.
- `SQUARE_SIDE`, default 60: hero sprite side in pixels.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `rst`  in  1: reset. Synchronous and active-high.
- `x_pos`  in  24: hero A x in [11:0], hero B x in [23:12].
- `y_pos`  in  24: hero A y in [11:0], hero B y in [23:12].
- `wall_addr`  out  ADDR_W: ROM address. Data for it is returned one cycle later.
- `wall_data`  in  48: wall fields are {x0[47:36], y0[35:24], x1[23:12], y1[11:0]}. The wall covers x0 ≤ x < x1 and y0 ≤ y < y1.
- `collision`  out  8: blocked flags.
  - Hero A: bit0 left, bit1 right, bit2 down, bit3 up.
  - Hero B: bit4 left, bit5 right, bit6 down, bit7 up.
- `scan_done`  out  1: one-cycle pulse on the cycle `collision` takes a new value.

## Operation
- The FSM has three states: LATCH, SCAN and COMMIT. The sequence is LATCH → SCAN (exactly NUM_WALLS cycles) → COMMIT → LATCH, repeating forever.
- LATCH:
  - Snapshot `x_pos`/`y_pos` into internal registers.
  - Clear the 8-bit accumulator.
  - Drive `wall_addr`=0.
- SCAN, cycle i (i = 0..NUM_WALLS-1):
  - `wall_data` holds wall i.
  - Drive `wall_addr` = i+1; the last address is don't-care.
  - OR the eight probe results against wall i into the accumulator.
- COMMIT:
  - `collision` <= accumulator, plus the mutual-blocking term if it is configured.
  - `scan_done` = 1.
- Probes are derived from the snapshot position (px, py) with S = SQUARE_SIDE:
  - left: (px-1, py)
  - right: (px+1, py)
  - down: (px, py+1)
  - up: (px, py-1)
- A probe (qx, qy) hits a wall when all of qx < x1, qx+S > x0, qy < y1 and qy+S > y0 hold.
- Width rules:
  - All probe arithmetic is 13 bits wide, zero-extended.
  - A left probe with px=0 is forced blocked; so is an up probe with py=0. These never wrap.
- Degenerate walls (x1 ≤ x0 or y1 ≤ y0) never hit.
- Position changes during SCAN are ignored until the next LATCH.
- `rst` takes effect on the next edge in any state, including mid-scan:
  - The FSM goes to LATCH and the accumulator clears.
  - `collision` = 8'hFF: all blocked until the first commit.
  - `scan_done` = 0 and `wall_addr` = 0.

## Timing
- Scan period is NUM_WALLS+2 cycles; with the default this is 34.
- Latency from position sample to the `collision` update is NUM_WALLS+2 cycles.
- If `rst` is deasserted at the edge ending cycle 0, then:
  - Cycle 1 is LATCH.
  - The first `scan_done`/`collision` update is visible in cycle NUM_WALLS+3.
- The ROM read latency is exactly 1 cycle. `wall_data` is sampled only in SCAN.
- `collision` is registered and has no combinational path from any input.

## Configuration
- `HERO_MUTUAL_BLOCK_EN`
  - Defined: in COMMIT, each hero's four probes are also tested against the other hero's snapshot square [x, x+S) × [y, y+S). Hits are ORed into that hero's bits, so the heroes cannot walk into each other.
  - Undefined: only walls contribute. Heroes may overlap, and no mutual-comparison logic is synthesized.

## Test plan
- Reset then idle:
  - Stimulus: `rst` held 3 cycles, NUM_WALLS=4, all walls degenerate, A=(542,648), B=(422,648).
  - Response: `collision`=8'hFF until the first `scan_done` at cycle 6 after release, then 8'h00. `wall_addr` sequence is 0,1,2,3.
- Wall adjacency:
  - Stimulus: wall {x0=602,y0=0,x1=700,y1=800}, A x=542.
  - Response: bit1=1 (probe 543+60 > 602). With A x=541, bit1=0.
- Top edge:
  - Stimulus: B y=0, no walls.
  - Response: bit7=1, bit6=0.
- Mid-scan update:
  - Stimulus: change A x during SCAN from clear to blocked.
  - Response: the current commit still shows the old result; the next commit shows the new one.
- Reset mid-scan:
  - Stimulus: assert `rst` at SCAN cycle 2.
  - Response: `collision`=8'hFF on the next cycle, and the scan restarts from LATCH with `wall_addr`=0.
- Mutual blocking:
  - Stimulus: with `HERO_MUTUAL_BLOCK_EN` defined, A=(500,300), B=(560,300), no walls.
  - Response: bit1=1 and bit4=1.
  - Without the macro: `collision`=8'h00.
